// File: rtl/heart_hud.sv
// heart_hud: lives tracker and HUD heart-row decoder driving a 15x15 heart sprite ROM.
// Maps raster position to ROM coordinates per heart slot and registers the ROM bit.
// The most recently lost heart blinks during the post-hit window.
// Optional macro HEART_HUD_INVULN_EN: hits are ignored while blinking and invuln is live.
module heart_hud #(
   parameter int MAX_LIVES    = 3,
   parameter int START_LIVES  = 3,
   parameter int X0           = 8,
   parameter int Y0           = 8,
   parameter int PITCH        = 18,
   parameter int BLINK_FRAMES = 60,
   parameter int BLINK_HALF   = 8
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [9:0] pix_x,
   input  logic [9:0] pix_y,
   input  logic       video_on,
   input  logic       frame_tick,
   input  logic       life_lost,
   input  logic       life_gain,
   input  logic       game_reset,
   output logic [3:0] heart_x,
   output logic [3:0] heart_y,
   output logic       heart_en,
   input  logic       heart_data,
   output logic       pixel_on,
   output logic [2:0] lives,
   output logic       game_over,
   output logic       invuln
);

   localparam int CW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

   typedef enum logic [1:0] {NORMAL, BLINK, OVER} state_t;

   state_t        state, state_nxt;
   logic [2:0]    lives_q, lives_nxt;
   logic [CW-1:0] cnt, cnt_nxt;
   logic          blink_phase;
   logic          lost_ok;
   logic          row_hit;

   logic [MAX_LIVES-1:0]      hit;
   logic [MAX_LIVES-1:0]      vis;
   logic [MAX_LIVES-1:0][3:0] hx;

   // lost heart is dark during even BLINK_HALF periods, lit during odd ones
   assign blink_phase = ((int'(cnt) / BLINK_HALF) % 2) == 1;

`ifdef HEART_HUD_INVULN_EN
   assign lost_ok = life_lost & (state != BLINK);
   assign invuln  = (state == BLINK);
`else
   assign lost_ok = life_lost;
   assign invuln  = 1'b0;
`endif

   assign lives     = lives_q;
   assign game_over = (state == OVER);

   // per-slot window comparators; slots never overlap since PITCH >= 15
   assign row_hit = (pix_y >= 10'(Y0)) && (pix_y <= 10'(Y0 + 14));

   for (genvar g = 0; g < MAX_LIVES; g++) begin : g_slot
      localparam int XS = X0 + g * PITCH;
      assign hit[g] = (pix_x >= 10'(XS)) && (pix_x <= 10'(XS + 14)) && row_hit;
      assign hx[g]  = 4'(pix_x - 10'(XS));
      assign vis[g] = (3'(g) < lives_q) ||
                      ((state == BLINK) && (3'(g) == lives_q) && blink_phase);
   end

   // select the matching slot's local coordinates and enable
   always_comb begin
      heart_x  = 4'd0;
      heart_y  = 4'd0;
      heart_en = 1'b0;
      for (int i = 0; i < MAX_LIVES; i++) begin
         if (hit[i]) begin
            heart_x  = hx[i];
            heart_y  = 4'(pix_y - 10'(Y0));
            heart_en = video_on & vis[i];
         end
      end
   end

   // next state: game_reset, then hit/extra-life events, then frame ticks
   always_comb begin
      state_nxt = state;
      lives_nxt = lives_q;
      cnt_nxt   = cnt;
      if (game_reset) begin
         state_nxt = NORMAL;
         lives_nxt = 3'(START_LIVES);
         cnt_nxt   = '0;
      end else if (state == OVER) begin
         // only a game reset leaves OVER
      end else if (lost_ok && life_gain) begin
         // hit and pickup cancel out
      end else if (lost_ok) begin
         cnt_nxt = '0;
         if (lives_q <= 3'd1) begin
            lives_nxt = 3'd0;
            state_nxt = OVER;
         end else begin
            lives_nxt = lives_q - 3'd1;
            state_nxt = BLINK;
         end
      end else if (life_gain) begin
         if (lives_q < 3'(MAX_LIVES))
            lives_nxt = lives_q + 3'd1;
      end else if (frame_tick && (state == BLINK)) begin
         if (cnt == CW'(BLINK_FRAMES - 1)) begin
            state_nxt = NORMAL;
            cnt_nxt   = '0;
         end else begin
            cnt_nxt = cnt + 1'b1;
         end
      end
   end

   // state, lives and blink counter registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= NORMAL;
         lives_q <= 3'(START_LIVES);
         cnt     <= '0;
      end else begin
         state   <= state_nxt;
         lives_q <= lives_nxt;
         cnt     <= cnt_nxt;
      end
   end

   // one-cycle registered heart pixel for the colour mux
   always_ff @(posedge clk or posedge rst) begin
      if (rst) pixel_on <= 1'b0;
      else     pixel_on <= heart_en & heart_data;
   end

endmodule

// File: tb/tb_heart_hud.sv
// tb_heart_hud: directed bench for heart_hud with a small lives/blink model and a
// scoreboard queue of expected pixel_on values. Stand-in ROM drives heart_data.
module tb_heart_hud;

`ifdef HEART_HUD_INVULN_EN
   localparam bit INV_EN = 1'b1;
`else
   localparam bit INV_EN = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       rst;
   logic [9:0] pix_x, pix_y;
   logic       video_on, frame_tick, life_lost, life_gain, game_reset;
   logic [3:0] heart_x, heart_y;
   logic       heart_en, heart_data, pixel_on;
   logic [2:0] lives;
   logic       game_over, invuln;

   int checks = 0;
   int errors = 0;

   int m_lives;
   bit m_blink, m_over;
   int m_cnt;
   bit exp_q[$];

   always #5 clk = ~clk;

   heart_hud dut (
      .clk(clk), .rst(rst), .pix_x(pix_x), .pix_y(pix_y), .video_on(video_on),
      .frame_tick(frame_tick), .life_lost(life_lost), .life_gain(life_gain),
      .game_reset(game_reset), .heart_x(heart_x), .heart_y(heart_y),
      .heart_en(heart_en), .heart_data(heart_data), .pixel_on(pixel_on),
      .lives(lives), .game_over(game_over), .invuln(invuln)
   );

   // stand-in sprite ROM; row 2 col 3 is set
   function automatic logic rom_bit(input logic [3:0] x, input logic [3:0] y);
      return ((int'(x) + 3 * int'(y)) % 5) != 0;
   endfunction

   assign heart_data = rom_bit(heart_x, heart_y);

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic m_reset();
      m_lives = 3; m_blink = 0; m_over = 0; m_cnt = 0;
   endtask

   // drive one pixel, check combinational outputs, score pixel_on a cycle later
   task automatic step_pix(input int x, input int y, input bit von);
      int s, ex, ey;
      bit een;
      @(negedge clk);
      pix_x = 10'(x); pix_y = 10'(y); video_on = von;
      s = -1;
      for (int i = 0; i < 3; i++)
         if (x >= 8 + 18 * i && x <= 22 + 18 * i && y >= 8 && y <= 22) s = i;
      ex  = (s >= 0) ? x - (8 + 18 * s) : 0;
      ey  = (s >= 0) ? y - 8 : 0;
      een = von && (s >= 0) &&
            ((s < m_lives) || (m_blink && s == m_lives && ((m_cnt / 8) % 2 == 1)));
      #1;
      chk("heart_x", 32'(heart_x), 32'(ex));
      chk("heart_y", 32'(heart_y), 32'(ey));
      chk("heart_en", 32'(heart_en), 32'(een));
      exp_q.push_back(een && rom_bit(4'(ex), 4'(ey)));
      @(posedge clk); #1;
      chk("pixel_on", 32'(pixel_on), 32'(exp_q.pop_front()));
   endtask

   // one-cycle control pulse plus model update
   task automatic pulse(input bit lo, input bit ga, input bit ti, input bit gr);
      bit lost_ok;
      @(negedge clk);
      life_lost = lo; life_gain = ga; frame_tick = ti; game_reset = gr;
      @(negedge clk);
      life_lost = 0; life_gain = 0; frame_tick = 0; game_reset = 0;
      lost_ok = lo && !(INV_EN && m_blink);
      if (gr) m_reset();
      else if (m_over) ;
      else if (lost_ok && ga) ;
      else if (lost_ok) begin
         m_cnt = 0;
         if (m_lives <= 1) begin m_lives = 0; m_over = 1; m_blink = 0; end
         else begin m_lives--; m_blink = 1; end
      end else if (ga) begin
         if (m_lives < 3) m_lives++;
      end else if (ti && m_blink) begin
         if (m_cnt == 59) begin m_blink = 0; m_cnt = 0; end
         else m_cnt++;
      end
   endtask

   task automatic ticks(input int n);
      for (int k = 0; k < n; k++) pulse(0, 0, 1, 0);
   endtask

   task automatic finish_blink();
      for (int k = 0; k < 70 && m_blink; k++) pulse(0, 0, 1, 0);
   endtask

   task automatic check_regs();
      chk("lives", 32'(lives), 32'(m_lives));
      chk("game_over", 32'(game_over), 32'(m_over));
      chk("invuln", 32'(invuln), 32'(INV_EN && m_blink));
   endtask

   task automatic probe_slots();
      for (int i = 0; i < 3; i++) step_pix(11 + 18 * i, 10, 1'b1);
   endtask

   initial begin
      rst = 1; pix_x = 0; pix_y = 0; video_on = 0;
      frame_tick = 0; life_lost = 0; life_gain = 0; game_reset = 0;
      m_reset();
      repeat (2) @(negedge clk);
      #1;
      check_regs();
      chk("reset_pixel_on", 32'(pixel_on), 32'd0);
      @(negedge clk); rst = 0;

      // full scan of slot 0
      for (int y = 8; y <= 22; y++)
         for (int x = 8; x <= 22; x++) step_pix(x, y, 1'b1);
      step_pix(11, 10, 1'b1);
      step_pix(23, 8, 1'b1);
      step_pix(26, 8, 1'b1);
      step_pix(10, 10, 1'b0);
      step_pix(100, 100, 1'b1);
      step_pix(7, 8, 1'b1);
      step_pix(62, 22, 1'b1);
      step_pix(20, 23, 1'b1);

      // first hit and full blink window
      pulse(1, 0, 0, 0); check_regs(); probe_slots();
      ticks(7); probe_slots();
      ticks(1); probe_slots();
      ticks(51); check_regs(); probe_slots();
      ticks(1); check_regs(); probe_slots();

      // second hit five frames into blink
      pulse(0, 0, 0, 1); check_regs();
      pulse(1, 0, 0, 0); ticks(5);
      pulse(1, 0, 0, 0); check_regs(); probe_slots();
      ticks(8); probe_slots();
      finish_blink(); check_regs(); probe_slots();

      // run out of lives
      pulse(0, 0, 0, 1);
      for (int k = 0; k < 3; k++) begin
         pulse(1, 0, 0, 0); check_regs();
         finish_blink();
      end
      check_regs(); probe_slots();
      pulse(0, 1, 0, 0); check_regs(); probe_slots();
      pulse(1, 0, 0, 0); check_regs();
      pulse(0, 0, 0, 1); check_regs(); probe_slots();

      // saturation and cancelling events
      pulse(0, 1, 0, 0); check_regs();
      pulse(1, 0, 0, 0); finish_blink(); check_regs();
      pulse(1, 1, 0, 0); check_regs();
      ticks(8); probe_slots(); check_regs();

      // async reset in the middle of a blink
      pulse(1, 0, 0, 0); ticks(3); check_regs();
      @(negedge clk); rst = 1; #1;
      m_reset(); check_regs();
      @(negedge clk); rst = 0;
      ticks(8); probe_slots(); check_regs();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
